clock_gate_ctrl: RTL and testbench

Activity-based controller that produces the `enable` for the clock-gating latch cell. It monitors a downstream `busy` indication and deasserts `enable` after a programmable run of idle cycles. It then restores the clock on a four-phase wake request/acknowledge handshake. It sits in the always-on `clk` domain, directly ahead of the gating latch.

---
 rtl/clock_gate_ctrl.sv | 108 ++++++++++
 tb/tb_clock_gate_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_gate_ctrl.sv
// rtl/clock_gate_ctrl.sv - activity-based clock-gate enable controller with four-phase wake handshake
// Optional gated-cycle statistics counter is built when CG_STATS_EN is defined.
module clock_gate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        busy,
  input  logic        gate_allow,
  input  logic        wake_req,
  output logic        enable,
  output logic        wake_ack,
  output logic        gated
`ifdef CG_STATS_EN
  ,
  output logic [15:0] gated_cycles
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_GATED = 2'd1,
    ST_WAKE  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] WAKE_LIM = CNT_W'(WAKE_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             enable_q, wake_ack_q, gated_q;

  assign cnt_inc = cnt_q + 1'b1;

  // One counter is shared: idle run-length in RUN, enable hold time in WAKE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (busy || wake_req || !gate_allow) begin
          cnt_d = '0;
        end else if (cnt_inc == IDLE_LIM) begin
          state_d = ST_GATED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_GATED: begin
        if (wake_req || !gate_allow) begin
          state_d = ST_WAKE;
          cnt_d   = '0;
        end
      end
      ST_WAKE: begin
        if (cnt_inc == WAKE_LIM) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      cnt_q      <= '0;
      enable_q   <= 1'b1;
      wake_ack_q <= 1'b0;
      gated_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      enable_q   <= (state_d != ST_GATED);
      wake_ack_q <= wake_req && (state_d == ST_RUN);
      gated_q    <= (state_d == ST_GATED);
    end
  end

  assign enable   = enable_q;
  assign wake_ack = wake_ack_q;
  assign gated    = gated_q;

`ifdef CG_STATS_EN
  logic [15:0] gated_cycles_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gated_cycles_q <= '0;
    end else if (state_q == ST_GATED && gated_cycles_q != 16'hFFFF) begin
      gated_cycles_q <= gated_cycles_q + 16'd1;
    end
  end

  assign gated_cycles = gated_cycles_q;
`endif

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// tb/tb_clock_gate_ctrl.sv - self-checking bench for clock_gate_ctrl
module tb_clock_gate_ctrl;

  localparam int IDLE = 16;
  localparam int WAKE = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy = 1'b0;
  logic gate_allow = 1'b1;
  logic wake_req = 1'b0;
  logic enable, wake_ack, gated;
`ifdef CG_STATS_EN
  logic [15:0] gated_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clock_gate_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .CNT_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .busy(busy),
    .gate_allow(gate_allow),
    .wake_req(wake_req),
    .enable(enable),
    .wake_ack(wake_ack),
    .gated(gated)
`ifdef CG_STATS_EN
    ,
    .gated_cycles(gated_cycles)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: clock stopped flag, remaining wake hold edges, idle run length.
  bit m_gated = 1'b0;
  int m_left  = 0;
  int m_run   = 0;
  bit m_ack   = 1'b0;
  int m_stat  = 0;
  bit n_gated, n_ack;
  int n_left, n_run, n_stat;

  always_comb begin
    n_gated = m_gated;
    n_left  = m_left;
    n_run   = m_run;
    n_stat  = (m_gated && m_stat < 65535) ? m_stat + 1 : m_stat;
    if (m_gated) begin
      if (wake_req || !gate_allow) begin
        n_gated = 1'b0;
        n_left  = WAKE;
      end
    end else if (m_left > 0) begin
      n_left = m_left - 1;
    end else if (!busy && !wake_req && gate_allow) begin
      n_run = m_run + 1;
      if (n_run == IDLE) begin
        n_gated = 1'b1;
        n_run   = 0;
      end
    end else begin
      n_run = 0;
    end
    n_ack = wake_req && !n_gated && (n_left == 0);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_gated <= 1'b0;
      m_left  <= 0;
      m_run   <= 0;
      m_ack   <= 1'b0;
      m_stat  <= 0;
    end else begin
      m_gated <= n_gated;
      m_left  <= n_left;
      m_run   <= n_run;
      m_ack   <= n_ack;
      m_stat  <= n_stat;
    end
  end

  always @(negedge clk) begin
    chk("model_enable", {31'd0, enable}, {31'd0, !m_gated});
    chk("model_gated", {31'd0, gated}, {31'd0, m_gated});
    chk("model_wake_ack", {31'd0, wake_ack}, {31'd0, m_ack});
`ifdef CG_STATS_EN
    chk("model_gated_cycles", {16'd0, gated_cycles}, m_stat);
`endif
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_enable", {31'd0, enable}, 32'd1);
    chk("reset_wake_ack", {31'd0, wake_ack}, 32'd0);
    chk("reset_gated", {31'd0, gated}, 32'd0);
    rst_n = 1'b1;

    // Gating latency from reset release
    for (int i = 1; i < IDLE; i++) begin
      @(negedge clk);
      chk("idle_enable_high", {31'd0, enable}, 32'd1);
    end
    @(negedge clk);
    chk("gate_enable_low", {31'd0, enable}, 32'd0);
    chk("gate_gated_high", {31'd0, gated}, 32'd1);
    chk("model_pin_gated", {31'd0, m_gated}, 32'd1);
    @(negedge clk);
`ifdef CG_STATS_EN
    chk("stats_first_gated_edge", {16'd0, gated_cycles}, 32'd1);
`endif

    // Wake from GATED with full handshake, then regate
    wake_req = 1'b1;
    @(negedge clk);
    chk("wake_enable_k", {31'd0, enable}, 32'd1);
    chk("wake_gated_k", {31'd0, gated}, 32'd0);
    chk("wake_ack_k", {31'd0, wake_ack}, 32'd0);
    @(negedge clk);
    chk("wake_ack_k1", {31'd0, wake_ack}, 32'd0);
    @(negedge clk);
    chk("wake_ack_k2", {31'd0, wake_ack}, 32'd1);
    chk("model_pin_ack", {31'd0, m_ack}, 32'd1);
    wake_req = 1'b0;
    @(negedge clk);
    chk("ack_drop", {31'd0, wake_ack}, 32'd0);
    repeat (IDLE - 2) @(negedge clk);
    chk("regate_before", {31'd0, enable}, 32'd1);
    @(negedge clk);
    chk("regate_after", {31'd0, enable}, 32'd0);

    // Busy pulse restarts the idle run
    wake_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("wake2_ack", {31'd0, wake_ack}, 32'd1);
    wake_req = 1'b0;
    repeat (10) @(negedge clk);
    busy = 1'b1;
    @(negedge clk);
    busy = 1'b0;
    repeat (IDLE - 1) @(negedge clk);
    chk("busy_restart_before", {31'd0, enable}, 32'd1);
    @(negedge clk);
    chk("busy_restart_after", {31'd0, enable}, 32'd0);

    // gate_allow dropped while GATED
    gate_allow = 1'b0;
    @(negedge clk);
    chk("noallow_enable", {31'd0, enable}, 32'd1);
    chk("noallow_gated", {31'd0, gated}, 32'd0);
    repeat (50) @(negedge clk);
    chk("noallow_hold_enable", {31'd0, enable}, 32'd1);
    chk("noallow_hold_ack", {31'd0, wake_ack}, 32'd0);
    chk("model_pin_noallow", {31'd0, m_gated}, 32'd0);

    // Wake request while already running
    wake_req = 1'b1;
    @(negedge clk);
    chk("run_wake_ack", {31'd0, wake_ack}, 32'd1);
    wake_req = 1'b0;
    @(negedge clk);
    chk("run_wake_ack_drop", {31'd0, wake_ack}, 32'd0);
    gate_allow = 1'b1;
    repeat (IDLE) @(negedge clk);
    chk("allow_regate", {31'd0, gated}, 32'd1);

    // Requester drops wake_req early: wake completes, no ack
    wake_req = 1'b1;
    @(negedge clk);
    wake_req = 1'b0;
    repeat (WAKE) @(negedge clk);
    chk("early_drop_enable", {31'd0, enable}, 32'd1);
    chk("early_drop_ack", {31'd0, wake_ack}, 32'd0);
    repeat (IDLE) @(negedge clk);
    chk("early_drop_regate", {31'd0, gated}, 32'd1);

    // Asynchronous reset between edges while GATED
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_enable", {31'd0, enable}, 32'd1);
    chk("async_rst_gated", {31'd0, gated}, 32'd0);
    chk("async_rst_ack", {31'd0, wake_ack}, 32'd0);
`ifdef CG_STATS_EN
    chk("async_rst_stats", {16'd0, gated_cycles}, 32'd0);
`endif
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (IDLE) @(negedge clk);
    chk("post_rst_gate", {31'd0, gated}, 32'd1);

`ifdef CG_STATS_EN
    repeat (70000) @(negedge clk);
    chk("stats_saturate", {16'd0, gated_cycles}, 32'h0000FFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
